// File: rtl/apb_slave_mem_if.sv
// APB completer-side bus bundle for apb_slave_mem.
// Signals:
//   psel, penable, pwrite, paddr[7:0], pwdata[7:0] : driven by the master
//   prdata[7:0], pready, pslverr                     : driven by the slave
// Modports:
//   master : drives request signals, observes the response
//   slave  : observes request signals, drives the response
interface apb_slave_mem_if;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer with a byte-wide register file, fixed wait states and an
// error response for addresses at or beyond DEPTH.
// Parameters:
//   DEPTH       : implemented byte locations 0..DEPTH-1 (1..256)
//   WAIT_CYCLES : access cycles with pready low before completion (0..15)
// Ports:
//   pclk   : bus clock, rising edge
//   preset : synchronous active-high reset (also clears the memory)
//   bus    : APB slave modport (psel/penable/pwrite/paddr/pwdata in,
//            prdata/pready/pslverr out, all outputs registered)
module apb_slave_mem #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic             pclk,
   input  logic             preset,
   apb_slave_mem_if.slave   bus
);

   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [8:0]  DEPTH_W = 9'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic [7:0] addr_q, wdata_q;
   logic       write_q, err_q;
   logic [7:0] mem [0:DEPTH-1];

   logic       capture;
   logic       commit;
   logic       enter_done;
   logic [7:0] sel_addr;
   logic       sel_write;
   logic       sel_err;

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      commit     = 1'b0;
      case (state)
         S_IDLE: begin
            // psel+penable without a setup cycle is ignored here
            if (bus.psel && !bus.penable) begin
               capture = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_next = S_DONE;
               end else begin
                  cnt_next   = 4'(WAIT_CYCLES);
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!bus.psel) begin
               state_next = S_IDLE;
            end else if (bus.penable) begin
               cnt_next = cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state_next = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (!bus.psel) begin
               state_next = S_IDLE;
            end else if (bus.penable) begin
               commit     = write_q && !err_q;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // With no wait states DONE is entered on the setup edge itself, so the
      // live request must be used instead of the not-yet-captured copy.
      sel_addr   = capture ? bus.paddr  : addr_q;
      sel_write  = capture ? bus.pwrite : write_q;
      sel_err    = capture ? ({1'b0, bus.paddr} >= DEPTH_W) : err_q;
      enter_done = (state != S_DONE) && (state_next == S_DONE);
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state       <= S_IDLE;
         cnt         <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         bus.prdata  <= '0;
         bus.pready  <= 1'b0;
         bus.pslverr <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (capture) begin
            addr_q  <= bus.paddr;
            wdata_q <= bus.pwdata;
            write_q <= bus.pwrite;
            err_q   <= sel_err;
         end
         bus.pready  <= (state_next == S_DONE);
         bus.pslverr <= (state_next == S_DONE) && sel_err;
         if (enter_done && !sel_write) begin
            bus.prdata <= sel_err ? 8'h00 : mem[sel_addr[AW-1:0]];
         end
         if (commit) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem. Four instances cover zero, two,
// three and one wait states, with DEPTH=64 and DEPTH=256. A byte-array
// model per instance predicts read data, error flags and transfer length.
module tb_apb_slave_mem;

   logic pclk = 1'b0;
   logic preset;
   always #5 pclk = ~pclk;

   int unsigned cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   apb_slave_mem_if bus0 ();
   apb_slave_mem_if bus1 ();
   apb_slave_mem_if bus2 ();
   apb_slave_mem_if bus3 ();

   apb_slave_mem #(.DEPTH(64),  .WAIT_CYCLES(0)) u0 (.pclk(pclk), .preset(preset), .bus(bus0.slave));
   apb_slave_mem #(.DEPTH(64),  .WAIT_CYCLES(3)) u1 (.pclk(pclk), .preset(preset), .bus(bus1.slave));
   apb_slave_mem #(.DEPTH(64),  .WAIT_CYCLES(2)) u2 (.pclk(pclk), .preset(preset), .bus(bus2.slave));
   apb_slave_mem #(.DEPTH(256), .WAIT_CYCLES(1)) u3 (.pclk(pclk), .preset(preset), .bus(bus3.slave));

   int unsigned depth_of [4] = '{64, 64, 64, 256};
   int unsigned wait_of  [4] = '{0, 3, 2, 1};
   logic [7:0]  model [4][256];

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic idle_if(input virtual apb_slave_mem_if vif);
      vif.psel    = 1'b0;
      vif.penable = 1'b0;
      vif.pwrite  = 1'b0;
      vif.paddr   = '0;
      vif.pwdata  = '0;
   endtask

   task automatic model_clear();
      for (int d = 0; d < 4; d++)
         for (int a = 0; a < 256; a++)
            model[d][a] = 8'h00;
   endtask

   // Reference behaviour of one completed transfer.
   task automatic model_xfer(input int d, input logic wr, input logic [7:0] a,
                             input logic [7:0] wd, output logic [7:0] erd,
                             output logic eerr, output int unsigned ecyc);
      eerr = (int'(a) >= int'(depth_of[d]));
      ecyc = 2 + wait_of[d];
      erd  = eerr ? 8'h00 : model[d][a];
      if (wr && !eerr) model[d][a] = wd;
   endtask

   // Drives one transfer starting now (just after an edge); returns after
   // the completion edge. Request fields are scrambled during access.
   task automatic xfer(input virtual apb_slave_mem_if vif, input logic wr,
                       input logic [7:0] a, input logic [7:0] wd,
                       output logic [7:0] rd, output logic err,
                       output int unsigned cycles, output logic after);
      vif.psel    = 1'b1;
      vif.penable = 1'b0;
      vif.pwrite  = wr;
      vif.paddr   = a;
      vif.pwdata  = wd;
      @(posedge pclk); #1;
      vif.penable = 1'b1;
      vif.paddr   = 8'($urandom);
      vif.pwdata  = 8'($urandom);
      vif.pwrite  = ~wr;
      cycles = 2;
      while (vif.pready !== 1'b1 && cycles < 40) begin
         @(posedge pclk); #1;
         cycles++;
      end
      rd  = vif.prdata;
      err = vif.pslverr;
      @(posedge pclk); #1;
      after = vif.pready;
      vif.psel    = 1'b0;
      vif.penable = 1'b0;
   endtask

   task automatic xfer_d(input int d, input logic wr, input logic [7:0] a,
                         input logic [7:0] wd, output logic [7:0] rd,
                         output logic err, output int unsigned cycles,
                         output logic after);
      case (d)
         0: xfer(bus0, wr, a, wd, rd, err, cycles, after);
         1: xfer(bus1, wr, a, wd, rd, err, cycles, after);
         2: xfer(bus2, wr, a, wd, rd, err, cycles, after);
         default: xfer(bus3, wr, a, wd, rd, err, cycles, after);
      endcase
   endtask

   task automatic test_reset();
      logic [7:0] rd; logic err, after; int unsigned c;
      preset = 1'b1;
      repeat (2) @(posedge pclk);
      #1;
      preset = 1'b0;
      model_clear();
      n_tests++;
      if ({bus0.pready, bus0.pslverr, bus0.prdata, bus3.pready, bus3.prdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got u0 rdy=%b err=%b rd=%h u3 rdy=%b rd=%h, want all 0",
                  bus0.pready, bus0.pslverr, bus0.prdata, bus3.pready, bus3.prdata);
      end
      xfer_d(0, 1'b0, 8'h05, 8'h00, rd, err, c, after);
      n_tests++;
      if ({rd, err, after} !== 10'h000 || c !== 2) begin
         n_fail++;
         $display("FAIL reset_read05: got rd=%h err=%b cyc=%0d after=%b, want rd=00 err=0 cyc=2 after=0",
                  rd, err, c, after);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rd; logic err, after; int unsigned c, t0;
      t0 = cyc;
      xfer_d(0, 1'b1, 8'h10, 8'hA5, rd, err, c, after);
      model[0][8'h10] = 8'hA5;
      xfer_d(0, 1'b0, 8'h10, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'hA5 || err !== 1'b0 || after !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_raw: got rd=%h err=%b after=%b, want rd=a5 err=0 after=0", rd, err, after);
      end
      n_tests++;
      if (cyc - t0 !== 4) begin
         n_fail++;
         $display("FAIL b2b_length: got %0d cycles for two transfers, want 4", cyc - t0);
      end
   endtask

   task automatic test_wait_states();
      logic [7:0] rd; logic err, after; int unsigned c;
      xfer_d(1, 1'b1, 8'h01, 8'h3C, rd, err, c, after);
      model[1][8'h01] = 8'h3C;
      n_tests++;
      if (c !== 5 || err !== 1'b0 || after !== 1'b0) begin
         n_fail++;
         $display("FAIL wait3_write: got cyc=%0d err=%b after=%b, want cyc=5 err=0 after=0", c, err, after);
      end
      xfer_d(1, 1'b0, 8'h01, 8'h00, rd, err, c, after);
      n_tests++;
      if (c !== 5 || rd !== 8'h3C || err !== 1'b0) begin
         n_fail++;
         $display("FAIL wait3_read: got cyc=%0d rd=%h err=%b, want cyc=5 rd=3c err=0", c, rd, err);
      end
   endtask

   task automatic test_addr_error();
      logic [7:0] rd; logic err, after; int unsigned c;
      xfer_d(0, 1'b1, 8'h00, 8'h5E, rd, err, c, after);
      model[0][8'h00] = 8'h5E;
      xfer_d(0, 1'b1, 8'h40, 8'hFF, rd, err, c, after);
      n_tests++;
      if (err !== 1'b1 || c !== 2) begin
         n_fail++;
         $display("FAIL err_write40: got err=%b cyc=%0d, want err=1 cyc=2", err, c);
      end
      xfer_d(0, 1'b0, 8'h40, 8'h00, rd, err, c, after);
      n_tests++;
      if (err !== 1'b1 || rd !== 8'h00) begin
         n_fail++;
         $display("FAIL err_read40: got err=%b rd=%h, want err=1 rd=00", err, rd);
      end
      xfer_d(0, 1'b0, 8'h3F, 8'h00, rd, err, c, after);
      n_tests++;
      if (err !== 1'b0 || rd !== 8'h00 || after !== 1'b0) begin
         n_fail++;
         $display("FAIL err_read3f: got err=%b rd=%h after=%b, want err=0 rd=00 after=0", err, rd, after);
      end
      xfer_d(0, 1'b0, 8'h00, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'h5E || err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_no_alias: got rd=%h err=%b at 0x00, want rd=5e err=0", rd, err);
      end
      xfer_d(3, 1'b1, 8'hFF, 8'hC3, rd, err, c, after);
      model[3][8'hFF] = 8'hC3;
      xfer_d(3, 1'b0, 8'hFF, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'hC3 || err !== 1'b0 || c !== 3) begin
         n_fail++;
         $display("FAIL depth256_ff: got rd=%h err=%b cyc=%0d, want rd=c3 err=0 cyc=3", rd, err, c);
      end
   endtask

   task automatic test_abort();
      logic [7:0] rd; logic err, after; int unsigned c, highs;
      bus2.psel = 1'b1; bus2.penable = 1'b0; bus2.pwrite = 1'b1;
      bus2.paddr = 8'h02; bus2.pwdata = 8'h77;
      @(posedge pclk); #1;
      bus2.psel = 1'b0; bus2.penable = 1'b0;
      highs = 0;
      repeat (6) begin
         @(posedge pclk); #1;
         if (bus2.pready !== 1'b0) highs++;
      end
      n_tests++;
      if (highs !== 0) begin
         n_fail++;
         $display("FAIL abort_no_ready: got %0d cycles with pready high, want 0", highs);
      end
      xfer_d(2, 1'b0, 8'h02, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'h00 || err !== 1'b0 || c !== 4) begin
         n_fail++;
         $display("FAIL abort_read02: got rd=%h err=%b cyc=%0d, want rd=00 err=0 cyc=4", rd, err, c);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd; logic err, after; int unsigned c;
      xfer_d(2, 1'b1, 8'h04, 8'h5A, rd, err, c, after);
      xfer_d(2, 1'b0, 8'h04, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'h5A) begin
         n_fail++;
         $display("FAIL rstmid_setup: got rd=%h, want 5a", rd);
      end
      bus2.psel = 1'b1; bus2.penable = 1'b0; bus2.pwrite = 1'b1;
      bus2.paddr = 8'h03; bus2.pwdata = 8'h11;
      @(posedge pclk); #1;
      bus2.penable = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1;
      @(posedge pclk); #1;
      n_tests++;
      if ({bus2.pready, bus2.pslverr, bus2.prdata} !== 10'h000) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got rdy=%b err=%b rd=%h, want 0 0 00",
                  bus2.pready, bus2.pslverr, bus2.prdata);
      end
      preset = 1'b0;
      idle_if(bus2);
      model_clear();
      @(posedge pclk); #1;
      xfer_d(2, 1'b0, 8'h03, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'h00 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_read03: got rd=%h err=%b, want 00 0", rd, err);
      end
      xfer_d(2, 1'b0, 8'h04, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'h00) begin
         n_fail++;
         $display("FAIL rstmid_cleared04: got rd=%h, want 00", rd);
      end
   endtask

   task automatic test_out_of_protocol();
      logic [7:0] rd; logic err, after; int unsigned c, highs;
      xfer_d(0, 1'b1, 8'h07, 8'h9D, rd, err, c, after);
      model[0][8'h07] = 8'h9D;
      bus0.psel = 1'b1; bus0.penable = 1'b1; bus0.pwrite = 1'b0; bus0.paddr = 8'h07;
      highs = 0;
      repeat (4) begin
         @(posedge pclk); #1;
         if (bus0.pready !== 1'b0) highs++;
      end
      n_tests++;
      if (highs !== 0) begin
         n_fail++;
         $display("FAIL oop_ignored: got %0d cycles with pready high, want 0", highs);
      end
      xfer_d(0, 1'b0, 8'h07, 8'h00, rd, err, c, after);
      n_tests++;
      if (rd !== 8'h9D || c !== 2) begin
         n_fail++;
         $display("FAIL oop_recover: got rd=%h cyc=%0d, want rd=9d cyc=2", rd, c);
      end
   endtask

   task automatic test_random();
      logic [7:0] rd, erd, a, wd; logic err, eerr, after, wr; int unsigned c, ec; int d;
      for (int i = 0; i < 200; i++) begin
         d  = int'($urandom_range(0, 3));
         wr = 1'($urandom);
         a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
         wd = 8'($urandom);
         model_xfer(d, wr, a, wd, erd, eerr, ec);
         xfer_d(d, wr, a, wd, rd, err, c, after);
         n_tests++;
         if (err !== eerr || c !== ec || after !== 1'b0 || (!wr && rd !== erd)) begin
            n_fail++;
            $display("FAIL random_%0d: dut%0d wr=%b a=%h got rd=%h err=%b cyc=%0d after=%b, want rd=%h err=%b cyc=%0d after=0",
                     i, d, wr, a, rd, err, c, after, erd, eerr, ec);
         end
         if ($urandom_range(0, 3) == 0) begin
            @(posedge pclk); #1;
         end
      end
   endtask

   initial begin
      idle_if(bus0); idle_if(bus1); idle_if(bus2); idle_if(bus3);
      preset = 1'b1;
      model_clear();
      @(posedge pclk); #1;
      test_reset();
      test_back_to_back();
      test_wait_states();
      test_addr_error();
      test_abort();
      test_reset_mid();
      test_out_of_protocol();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

APB completer holding a byte-wide register file, with a programmable number of wait states and an error response for out-of-range addresses. It sits on the far end of the team's APB master bridge, answering that master's `psel`/`penable` transfers. It is the bus target used for master bring-up and for system-level register storage. Every output is registered.

## Interface
- `DEPTH`, default 64: number of implemented byte locations, at addresses 0..DEPTH-1. Legal range is 1..256.
- `WAIT_CYCLES`, default 0: number of access-phase cycles with `pready` low before completion. Legal range is 0..15.
- `pclk`, input, 1: bus clock. All logic is on the rising edge.
- `preset`, input, 1: reset, synchronous and active-high.
- `psel`, input, 1: slave select from the master.
- `penable`, input, 1: access-phase strobe from the master.
- `pwrite`, input, 1: 1 = write, 0 = read.
- `paddr`, input, 8: byte address.
- `pwdata`, input, 8: write data.
- `prdata`, output, 8: read data. Valid while `pready`=1 on a read.
- `pready`, output, 1: transfer-complete indication.
- `pslverr`, output, 1: error flag. Valid only while `pready`=1.

## Operation
- Storage is `mem[0..DEPTH-1]`, 8 bits per entry.
- State machine states are IDLE, WAIT and DONE.
- IDLE:
  - `pready`=0.
  - At an edge with `psel`=1 and `penable`=0 (setup phase), capture `paddr`, `pwrite` and `pwdata`.
  - Set `err = (paddr >= DEPTH)`.
  - If WAIT_CYCLES=0, go to DONE. Otherwise load `cnt` with WAIT_CYCLES and go to WAIT.
- WAIT:
  - `pready`=0.
  - At each edge with `psel`=1 and `penable`=1, decrement `cnt`. When `cnt` reaches 0, go to DONE.
  - If `psel`=0 at an edge (master abort), go to IDLE. There is no write and no change to `prdata`.
- Entering DONE (the same edge that raises `pready`):
  - Set `pready`=1 and `pslverr`=`err`.
  - On a read with `err`=0, load `prdata` with `mem[addr_q]`.
  - On a read with `err`=1, load `prdata` with 0x00.
- DONE:
  - At the next edge with `psel`=1 and `penable`=1, the transfer completes.
  - On a write with `err`=0, `mem[addr_q]` is written with `wdata_q` at that edge.
  - On a write with `err`=1, memory is unchanged.
  - Go to IDLE. `pready` and `pslverr` return to 0.
  - If `psel`=0 at that edge (abort), go to IDLE with no write.
- Data and address:
  - `paddr`, `pwdata` and `pwrite` are used only as captured at setup. Changes during the access phase are ignored.
  - `prdata` holds its last loaded value outside DONE.
- Out-of-protocol input: `psel`=1 and `penable`=1 seen in IDLE (no setup cycle) is ignored. The block stays in IDLE and `pready` stays 0.
- Back-to-back transfers: the cycle after completion is evaluated in IDLE, so a new setup phase there is accepted with no dead cycle.

## Timing
- Reset, at a `pclk` edge with `preset`=1:
  - State goes to IDLE and `cnt`=0.
  - `prdata`=0x00, `pready`=0, `pslverr`=0.
  - All `mem` entries are cleared to 0x00.
  - Reset mid-transfer abandons the transfer. A pending write is not committed.
- Transfer length is 2+WAIT_CYCLES cycles: one setup cycle, WAIT_CYCLES access cycles with `pready`=0, then one access cycle with `pready`=1.
- `pready` is high for exactly one cycle per completed transfer.
- Read-after-write to the same address, back-to-back: the read returns the new data. The write commits at the completion edge, which is before the read's DONE entry.
- Address and error arithmetic:
  - 8-bit address compare against DEPTH.
  - When DEPTH=256, no address errors.
  - `cnt` is 4 bits.

## Test plan
- Reset, then read 0x05 with WAIT_CYCLES=0 -> `pready`=1 in the cycle after setup, `prdata`=0x00, `pslverr`=0, total 2 cycles.
- Write 0xA5 to 0x10, then read 0x10 back-to-back -> read returns `prdata`=0xA5, `pslverr`=0, with no idle cycle between the transfers.
- WAIT_CYCLES=3, write 0x3C to 0x01, then read 0x01 -> `pready` is low for 3 access cycles and high on the 4th, read returns 0x3C, each transfer takes 5 cycles.
- DEPTH=64: write 0xFF to 0x40, then read 0x40 -> `pready`=1 with `pslverr`=1, read data 0x00, `mem` unchanged. Then read 0x3F -> `pslverr`=0.
- WAIT_CYCLES=2: drop `psel` during the first wait cycle of a write of 0x77 to 0x02 -> no `pready` pulse, and a later read of 0x02 returns 0x00.
- Assert `preset` during WAIT of a write of 0x11 to 0x03 -> all outputs are 0 the next cycle, and a read of 0x03 after reset returns 0x00.
